// File: rtl/pr_pkg.sv
// Shared types and helpers for the partial-reconfiguration bitstream path
// (DDR line reads feeding the ICAP write port).
package pr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

  localparam int DDR_LINE_BYTES = 64;
  localparam int BEATS_PER_READ = 2;
  localparam int ICAP_W         = 32;
  localparam int DDR_BEAT_W     = 256;
  localparam int WORDS_PER_BEAT = DDR_BEAT_W / ICAP_W;

  // ICAP expects each byte with its bit order reversed.
  function automatic logic [ICAP_W-1:0] bit_rev_bytes(input logic [ICAP_W-1:0] w);
    logic [ICAP_W-1:0] r;
    r = '0;
    for (int b = 0; b < ICAP_W / 8; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b+i] = w[8*b+7-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pr_beat_fifo.sv
// Synchronous FIFO for DDR beats with occupancy output and a flush that
// empties it in one cycle. Pushes when full and pops when empty are ignored.
module pr_beat_fifo #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [AW:0]       occ_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam logic [AW:0] DEPTH_OCC = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       occ_q, occ_d;
  logic              do_push, do_pop;

  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == DEPTH_OCC);
  assign occ_o   = occ_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/icap_bitstream_feeder.sv
// Requests 64 B DDR line reads, buffers the 256 b beats and serialises them
// into 32 b ICAP write words, one word per cycle unless ICAP holds off.
//
// Handshake: a beat is taken on every cycle i_ddr_rd_data_valid is high (no
// back-pressure); the controller must only start a read while
// o_config_buff_full is low. An ICAP word is transferred on every cycle
// o_icap_csib is low, which happens only when a word is held and i_icap_hold=0.
module icap_bitstream_feeder
  import pr_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_W      = 21,
  parameter int BIT_SWAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [NUM_W-1:0]      i_num_reads,
  input  logic                  i_abort,
  output logic                  o_ddr_rd,
  input  logic [DDR_BEAT_W-1:0] i_ddr_data,
  input  logic                  i_ddr_rd_data_valid,
  input  logic                  i_ddr_rd_done,
  output logic                  o_config_buff_full,
  input  logic                  i_icap_hold,
  output logic                  o_icap_csib,
  output logic                  o_icap_rdwrb,
  output logic [ICAP_W-1:0]     o_icap_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_ovf,
  output logic [1:0]            o_dbg_state
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OCC_W-1:0] FULL_THR = OCC_W'(FIFO_DEPTH - 2);

  feeder_state_e         state_q, state_d;
  logic [NUM_W-1:0]      num_q, num_d;
  logic [NUM_W-1:0]      issued_q, issued_d, issued_inc;
  logic                  ddr_rd_q, ddr_rd_d;
  logic                  err_ovf_q, err_ovf_d;
  logic [DDR_BEAT_W-1:0] ser_q, ser_d;
  logic [2:0]            ser_idx_q, ser_idx_d;
  logic                  ser_vld_q, ser_vld_d;

  logic                  flush;
  logic                  push_req;
  logic                  ser_load;
  logic                  consume;
  logic                  last_word;
  logic [DDR_BEAT_W-1:0] fifo_dout;
  logic [OCC_W-1:0]      fifo_occ;
  logic                  fifo_empty, fifo_full;
  logic [ICAP_W-1:0]     raw_word;

  // Beats outside an active transfer are late data from an abort: dropped.
  assign push_req   = i_ddr_rd_data_valid & ((state_q == RUN) | (state_q == DRAIN)) & ~i_abort;
  assign issued_inc = issued_q + 1'b1;

  pr_beat_fifo #(
    .DATA_W (DDR_BEAT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push_req),
    .pop_i   (ser_load),
    .data_i  (i_ddr_data),
    .data_o  (fifo_dout),
    .occ_o   (fifo_occ),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    issued_d  = issued_q;
    ddr_rd_d  = ddr_rd_q;
    err_ovf_d = err_ovf_q;
    flush     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          err_ovf_d = 1'b0;
          num_d     = i_num_reads;
          issued_d  = '0;
          if (i_num_reads != '0) begin
            state_d  = RUN;
            ddr_rd_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (i_ddr_rd_done && (issued_q != num_q)) begin
          issued_d = issued_inc;
          if (issued_inc == num_q) begin
            ddr_rd_d = 1'b0;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty && !ser_vld_q && !push_req) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (push_req && fifo_full) err_ovf_d = 1'b1;
    if (i_abort) begin
      state_d  = IDLE;
      ddr_rd_d = 1'b0;
      flush    = 1'b1;
    end
  end

  // Serialiser reloads on the same cycle word 7 leaves, so beats stream gap-free.
  assign consume   = ser_vld_q & ~i_icap_hold;
  assign last_word = (ser_idx_q == 3'd7);
  assign ser_load  = ~fifo_empty & (~ser_vld_q | (consume & last_word)) & ~flush;

  always_comb begin
    ser_d     = ser_q;
    ser_idx_d = ser_idx_q;
    ser_vld_d = ser_vld_q;
    if (ser_load) begin
      ser_d     = fifo_dout;
      ser_idx_d = 3'd0;
      ser_vld_d = 1'b1;
    end else if (consume) begin
      ser_idx_d = ser_idx_q + 3'd1;
      if (last_word) ser_vld_d = 1'b0;
    end
    if (flush) begin
      ser_idx_d = 3'd0;
      ser_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      issued_q  <= '0;
      ddr_rd_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      ser_q     <= '0;
      ser_idx_q <= 3'd0;
      ser_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      issued_q  <= issued_d;
      ddr_rd_q  <= ddr_rd_d;
      err_ovf_q <= err_ovf_d;
      ser_q     <= ser_d;
      ser_idx_q <= ser_idx_d;
      ser_vld_q <= ser_vld_d;
    end
  end

  assign raw_word = ser_q[{ser_idx_q, 5'b0} +: ICAP_W];

  always_comb begin
    o_icap_data = '0;
    if (ser_vld_q) o_icap_data = (BIT_SWAP != 0) ? bit_rev_bytes(raw_word) : raw_word;
  end

  assign o_icap_csib        = ~consume;
  assign o_icap_rdwrb       = 1'b0;
  assign o_ddr_rd           = ddr_rd_q;
  assign o_config_buff_full = (fifo_occ > FULL_THR);
  assign o_busy             = (state_q == RUN) | (state_q == DRAIN);
  assign o_done             = (state_q == DONE);
  assign o_err_ovf          = err_ovf_q;
  assign o_dbg_state        = state_q;

endmodule

// File: tb/tb_icap_bitstream_feeder.sv
// Self-checking bench: a DDR controller model feeds two feeders (pass-through
// and bit-swapped); a scoreboard checks every ICAP word in order.
module tb_icap_bitstream_feeder;

  localparam int NUM_W = 21;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NUM_W-1:0] num_reads;
  logic             abort;
  logic [255:0]     ddr_data;
  logic             dv;
  logic             rd_done;
  logic             hold;

  logic        ddr_rd_a, full_a, csib_a, rdwrb_a, busy_a, done_a, ovf_a;
  logic [31:0] data_a;
  logic [1:0]  state_a;
  logic        ddr_rd_b, full_b, csib_b, rdwrb_b, busy_b, done_b, ovf_b;
  logic [31:0] data_b;
  logic [1:0]  state_b;

  icap_bitstream_feeder #(.FIFO_DEPTH(8), .NUM_W(NUM_W), .BIT_SWAP(0)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_num_reads(num_reads), .i_abort(abort),
    .o_ddr_rd(ddr_rd_a), .i_ddr_data(ddr_data), .i_ddr_rd_data_valid(dv),
    .i_ddr_rd_done(rd_done), .o_config_buff_full(full_a), .i_icap_hold(hold),
    .o_icap_csib(csib_a), .o_icap_rdwrb(rdwrb_a), .o_icap_data(data_a),
    .o_busy(busy_a), .o_done(done_a), .o_err_ovf(ovf_a), .o_dbg_state(state_a)
  );

  icap_bitstream_feeder #(.FIFO_DEPTH(8), .NUM_W(NUM_W), .BIT_SWAP(1)) dut_swap (
    .clk(clk), .rst(rst), .i_start(start), .i_num_reads(num_reads), .i_abort(abort),
    .o_ddr_rd(ddr_rd_b), .i_ddr_data(ddr_data), .i_ddr_rd_data_valid(dv),
    .i_ddr_rd_done(rd_done), .o_config_buff_full(full_b), .i_icap_hold(hold),
    .o_icap_csib(csib_b), .o_icap_rdwrb(rdwrb_b), .o_icap_data(data_b),
    .o_busy(busy_b), .o_done(done_b), .o_err_ovf(ovf_b), .o_dbg_state(state_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0]  exp_q[$];
  logic [31:0]  exp_sw_q[$];
  logic [255:0] beat_src_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int reads_cnt = 0;
  int words_a = 0;
  int first_dv_cyc = -1;
  int first_word_cyc = -1;
  bit drop_exp = 1'b0;
  bit rd_seen = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 8; j++)
        r[8*b + (7-j)] = w[8*b + j];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- DDR controller model (driver) ----------------
  initial begin
    logic [255:0] beat;
    dv = 1'b0; rd_done = 1'b0; ddr_data = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && ddr_rd_a && !full_a) begin
        for (int b = 0; b < 2; b++) begin
          if (beat_src_q.size() > 0) beat = beat_src_q.pop_front();
          else for (int k = 0; k < 8; k++) beat[32*k +: 32] = $urandom();
          ddr_data = beat;
          dv = 1'b1;
          if (first_dv_cyc < 0) first_dv_cyc = cyc;
          if (!drop_exp) begin
            for (int k = 0; k < 8; k++) begin
              exp_q.push_back(beat[32*k +: 32]);
              exp_sw_q.push_back(swap_bytes(beat[32*k +: 32]));
            end
          end
          @(posedge clk); #1;
        end
        dv = 1'b0;
        rd_done = 1'b1;
        @(posedge clk); #1;
        rd_done = 1'b0;
        reads_cnt++;
      end
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (done_a) done_cnt++;
      if (ddr_rd_a) rd_seen = 1'b1;
      check("csib_match", csib_b, csib_a);
      if (!csib_a) begin
        if (first_word_cyc < 0) first_word_cyc = cyc;
        words_a++;
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("icap_word", data_a, exp_q.pop_front());
      end
      if (!csib_b) begin
        check("word_sw_expected", exp_sw_q.size() > 0, 1);
        if (exp_sw_q.size() > 0) check("icap_word_swap", data_b, exp_sw_q.pop_front());
      end
    end
  end

  task automatic start_xfer(input int num);
    num_reads = NUM_W'(num);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int max, input bit rand_hold);
    int n = 0;
    while (done_cnt == base && n < max) begin
      if (rand_hold) hold = 1'($urandom_range(0, 1));
      tick(1);
      n++;
    end
    hold = 1'b0;
    check({tag, "_done_seen"}, done_cnt > base, 1);
    tick(4);
    check({tag, "_done_once"}, done_cnt - base, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ddr_rd"}, ddr_rd_a, 0);
    check({tag, "_csib"}, csib_a, 1);
    check({tag, "_data"}, data_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_ovf"}, ovf_a, 0);
    check({tag, "_full"}, full_a, 0);
    check({tag, "_state"}, state_a, 0);
    check({tag, "_rdwrb"}, rdwrb_a, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base, r0, w0, n;
    logic [255:0] beat;
    rst = 1'b1; start = 1'b0; num_reads = '0; abort = 1'b0; hold = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // 1) single read, known words, pass-through and latency
    for (int k = 0; k < 8; k++) beat[32*k +: 32] = 32'(k + 1);
    beat_src_q.push_back(beat);
    for (int k = 0; k < 8; k++) beat[32*k +: 32] = 32'(k + 9);
    beat_src_q.push_back(beat);
    first_dv_cyc = -1; first_word_cyc = -1;
    base = done_cnt; r0 = reads_cnt; w0 = words_a;
    start_xfer(1);
    wait_done("t1", base, 200, 1'b0);
    check("t1_latency", first_word_cyc - first_dv_cyc, 2);
    check("t1_words", words_a - w0, 16);
    check("t1_reads", reads_cnt - r0, 1);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_ddr_rd_low", ddr_rd_a, 0);

    // 2) bit swap of known words
    beat = '0;
    beat[31:0]  = 32'h0000_0001;
    beat[63:32] = 32'h1234_5678;
    beat_src_q.push_back(beat);
    base = done_cnt;
    start_xfer(1);
    n = 0;
    while (csib_b && n < 50) begin @(negedge clk); n++; end
    check("t2_first_word_seen", csib_b, 0);
    check("t2_swap_0x1", data_b, 32'h0000_0080);
    @(negedge clk);
    check("t2_swap_0x12345678", data_b, 32'h482C_6A1E);
    tick(1);
    wait_done("t2", base, 200, 1'b0);

    // 3) ICAP held: buffer fills, controller throttled, then drains
    hold = 1'b1;
    base = done_cnt; r0 = reads_cnt; w0 = words_a;
    start_xfer(8);
    tick(60);
    check("t3_full", full_a, 1);
    check("t3_reads_stalled", reads_cnt - r0, 4);
    check("t3_no_ovf", ovf_a, 0);
    check("t3_ddr_rd_held", ddr_rd_a, 1);
    check("t3_busy", busy_a, 1);
    hold = 1'b0;
    wait_done("t3", base, 3000, 1'b0);
    check("t3_reads_total", reads_cnt - r0, 8);
    check("t3_words", words_a - w0, 128);
    check("t3_queue_empty", exp_sw_q.size(), 0);
    check("t3_no_ovf_end", ovf_a, 0);
    check("t3_ddr_rd_low", ddr_rd_a, 0);

    // 4) zero-length transfer
    rd_seen = 1'b0;
    base = done_cnt;
    start_xfer(0);
    check("t4_done_next_cycle", done_a, 1);
    tick(1);
    check("t4_done_pulse_end", done_a, 0);
    check("t4_state_idle", state_a, 0);
    tick(3);
    check("t4_done_count", done_cnt - base, 1);
    check("t4_no_ddr_rd", rd_seen, 0);

    // 5) abort while a read is in flight
    base = done_cnt; r0 = reads_cnt;
    start_xfer(4);
    n = 0;
    while (!(reads_cnt > r0 && dv) && n < 200) begin tick(1); n++; end
    check("t5_reached_read2", reads_cnt > r0 && dv, 1);
    drop_exp = 1'b1;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    exp_q.delete();
    exp_sw_q.delete();
    check("t5_state_idle", state_a, 0);
    check("t5_csib", csib_a, 1);
    check("t5_busy", busy_a, 0);
    check("t5_ddr_rd", ddr_rd_a, 0);
    tick(20);
    check("t5_no_done", done_cnt - base, 0);
    check("t5_no_ovf", ovf_a, 0);
    check("t5_still_idle", state_a, 0);
    check("t5_full_clear", full_a, 0);
    drop_exp = 1'b0;

    // 6) async reset during DRAIN, then a clean random-hold transfer
    hold = 1'b1;
    start_xfer(2);
    tick(40);
    check("t6_in_drain", state_a, 2);
    #2;
    hold = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async_reset");
    exp_q.delete();
    exp_sw_q.delete();
    tick(2);
    rst = 1'b0;
    tick(2);
    base = done_cnt; r0 = reads_cnt; w0 = words_a;
    start_xfer(6);
    wait_done("t6", base, 4000, 1'b1);
    check("t6_reads", reads_cnt - r0, 6);
    check("t6_words", words_a - w0, 96);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_no_ovf", ovf_a, 0);

    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule
